corr_dump_engine: RTL and testbench
===================================

# corr_dump_engine

Multi-channel correlator dump capture engine that sits between the tracking channels and the bus interface of `gps_baseband`. It latches Early/Prompt/Late I/Q accumulations when any channel dumps and computes E/P/L power (I²+Q²) with one shared multiplier. Each result is pushed as a tagged record into a FIFO that software drains via a valid/ready port. It removes per-dump register polling and adds overrun accounting.

## Interface
Parameters:
- `NUM_CH`, 4: number of tracking channels serviced, 1–16.
- `ACC_W`, 16: signed accumulator width per I/Q value.
- `FIFO_DEPTH`, 8: record FIFO depth, power of two, ≥2.

Derived widths:
- `CH_W` = max(1, clog2(NUM_CH)).
- `PW` = 2·ACC_W.
- `LVL_W` = clog2(FIFO_DEPTH)+1.

Ports:
- `clk` in 1: baseband clock, 16.368 MHz.
- `hw_rst` in 1: reset, synchronous, active-high.
- `ch_dump` in NUM_CH: one-cycle dump pulse per channel.
- `acc_flat` in NUM_CH·6·ACC_W: per channel, order IE,QE,IP,QP,IL,QL, LSB first. Values are stable from the dump until the next dump of that channel.
- `rec_valid` out 1: FIFO head valid.
- `rec_ready` in 1: consumer accepts head.
- `rec_data` out REC_W: {ch_id[CH_W], seq[8], powE[PW], powP[PW], powL[PW]}, plus optional IQ field (see Configuration).
- `fifo_level` out LVL_W: records held.
- `ovf` out 1: sticky; a record was dropped or a dump was missed.
- `drop_cnt` out 8: saturating count of lost records.
- `clr_ovf` in 1: clears `ovf` and `drop_cnt`.
- `irq` out 1: registered, high while fifo_level ≠ 0.

## Operation
- Per-channel `pending[c]` flag is set by `ch_dump[c]`.
- A dump arriving while `pending[c]` is already set is a miss: `pending` stays set, `drop_cnt` increments, `ovf` is set.
- Per-channel 8-bit `seq[c]` increments on every dump, including missed ones, and wraps 255→0. It tags the dump being served so software can detect gaps.
- FSM states:
  - IDLE: pick the lowest-index pending channel at or above the round-robin pointer, wrapping. Go to LATCH.
  - LATCH: copy that channel's 6 values and seq into a snapshot; clear `pending[c]`; advance the pointer to c+1 mod NUM_CH.
  - MUL: 6 cycles, one square per cycle in order IE,QE,IP,QP,IL,QL. Each square is accumulated into the corresponding powE/P/L.
  - PUSH: write the record if the FIFO is not full. Otherwise discard it, increment `drop_cnt` and set `ovf`. Return to IDLE.
- Arithmetic:
  - Squares are computed on sign-extended values and are unsigned.
  - Maximum sum is 2·(2^(ACC_W−1))² = 2^(2·ACC_W−1), which fits in PW with no saturation.
  - (−32768)² + (−32768)² = 0x8000_0000 for ACC_W=16.
- Simultaneous events:
  - Dump of channel c in the same cycle LATCH clears it: set wins, so pending stays 1 and that is not a miss.
  - `clr_ovf` coincident with a new loss: the loss wins, so ovf=1 and drop_cnt=1.
  - `drop_cnt` saturates at 255.
- FIFO: push and pop in the same cycle while full is not permitted, because the push is evaluated against the pre-pop level. Same-cycle push and pop otherwise keeps `fifo_level` constant.

## Timing
- Service latency from a `ch_dump` pulse in IDLE to `rec_valid`:
  - dump registered at cycle 0;
  - LATCH at cycle 1;
  - MUL at cycles 2–7;
  - PUSH at cycle 8;
  - `rec_valid`=1 at cycle 9 when the FIFO was empty.
- Throughput is one record per 9 cycles (IDLE, LATCH, 6×MUL, PUSH). Worst case for all channels at NUM_CH=16 is 144 cycles, far below the 16368-cycle 1 ms epoch.
- `rec_data` is valid whenever `rec_valid`=1. The head pops on the rising edge where `rec_valid & rec_ready`.
- `irq` follows `fifo_level` with 1 cycle of lag.
- Reset values: FSM in IDLE; all pending=0; seq=0; pointer=0; FIFO empty; rec_valid=0; rec_data=0; fifo_level=0; ovf=0; drop_cnt=0; irq=0.
- Reset mid-operation: the in-flight record is discarded and nothing is pushed.

## Configuration
- `CORR_DUMP_IQ_EN` defined: the record is extended with {IP[ACC_W], QP[ACC_W]} at the LSB end, and REC_W grows by 2·ACC_W. This supports software phase discriminators.
- `CORR_DUMP_IQ_EN` undefined: the record carries powers only; REC_W = CH_W+8+3·PW. Timing is identical in both builds.

## Test plan
- NUM_CH=4, ch2 dumps with IE=3,QE=4,IP=−1000,QP=0,IL=0,QL=−5 → at cycle 9: record ch=2, seq=1, powE=25, powP=1000000, powL=25, irq=1.
- All four channels pulse the same cycle, pointer=0 → four records in order ch0,1,2,3, spaced 9 cycles apart, fifo_level=4.
- All six inputs = −32768 → powE=powP=powL=0x8000_0000.
- FIFO_DEPTH=8, rec_ready=0, 10 dumps → 8 records kept, drop_cnt=2, ovf=1. Then clr_ovf → 0/0 while FIFO stays full.
- ch1 dumps twice within 3 cycles while the engine is busy on ch0 → drop_cnt=1, a single ch1 record with seq=2.
- hw_rst asserted in MUL → no record and all outputs at reset values next cycle. With `CORR_DUMP_IQ_EN`, case 1 additionally shows IP=−1000, QP=0 in the record LSBs.

Source files
------------

// File: rtl/corr_dump_engine.sv
// Correlator dump capture engine: services channel dumps round-robin, squares E/P/L I/Q with one
// shared multiplier and queues tagged power records. Define CORR_DUMP_IQ_EN to append IP/QP.
module corr_dump_engine #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned ACC_W      = 16,
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned PW    = 2 * ACC_W,
    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1,
`ifdef CORR_DUMP_IQ_EN
    localparam int unsigned IQ_W  = 2 * ACC_W,
`else
    localparam int unsigned IQ_W  = 0,
`endif
    localparam int unsigned REC_W = CH_W + 8 + 3 * PW + IQ_W
) (
    input  logic                      clk,
    input  logic                      hw_rst,
    input  logic [NUM_CH-1:0]         ch_dump,
    input  logic [NUM_CH*6*ACC_W-1:0] acc_flat,
    output logic                      rec_valid,
    input  logic                      rec_ready,
    output logic [REC_W-1:0]          rec_data,
    output logic [LVL_W-1:0]          fifo_level,
    output logic                      ovf,
    output logic [7:0]                drop_cnt,
    input  logic                      clr_ovf,
    output logic                      irq
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StLatch, StMul, StPush} state_e;

    state_e                   state;
    logic [NUM_CH-1:0]        pending;
    logic [7:0]               seq [NUM_CH];
    logic [CH_W-1:0]          ptr;
    logic [CH_W-1:0]          cur_ch;
    logic signed [ACC_W-1:0]  snap [6];
    logic [7:0]               snap_seq;
    logic [2:0]               mul_idx;
    logic [PW-1:0]            pow_e, pow_p, pow_l;
    logic [REC_W-1:0]         mem [FIFO_DEPTH];
    logic [AW-1:0]            wr_ptr, rd_ptr;
    logic [LVL_W-1:0]         level;

    // Round-robin pick: lowest pending index at or above ptr, else lowest overall.
    logic [CH_W-1:0] sel_ch, lo_ch, hi_ch;
    logic            sel_found, hi_found;

    always_comb begin
        lo_ch     = '0;
        hi_ch     = '0;
        sel_found = 1'b0;
        hi_found  = 1'b0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (pending[c]) begin
                lo_ch     = CH_W'(c);
                sel_found = 1'b1;
                if (c >= int'(ptr)) begin
                    hi_ch    = CH_W'(c);
                    hi_found = 1'b1;
                end
            end
        end
        sel_ch = hi_found ? hi_ch : lo_ch;
    end

    logic signed [ACC_W-1:0] lat_val [6];
    logic [7:0]              lat_seq;

    always_comb begin
        lat_seq = '0;
        for (int k = 0; k < 6; k++) lat_val[k] = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (CH_W'(c) == cur_ch) begin
                lat_seq = seq[c];
                for (int k = 0; k < 6; k++) lat_val[k] = acc_flat[(c * 6 + k) * ACC_W +: ACC_W];
            end
        end
    end

    logic signed [ACC_W-1:0] mul_op;
    logic signed [PW-1:0]    mul_ext;
    logic [PW-1:0]           mul_sq;

    always_comb begin
        mul_op = snap[0];
        case (mul_idx)
            3'd1:    mul_op = snap[1];
            3'd2:    mul_op = snap[2];
            3'd3:    mul_op = snap[3];
            3'd4:    mul_op = snap[4];
            3'd5:    mul_op = snap[5];
            default: ;
        endcase
        mul_ext = PW'(mul_op);
        mul_sq  = mul_ext * mul_ext;
    end

    logic fifo_full, push, push_drop, pop;

    assign fifo_full  = (level == LVL_W'(FIFO_DEPTH));
    assign push       = (state == StPush) && !fifo_full;
    assign push_drop  = (state == StPush) && fifo_full;
    assign rec_valid  = (level != '0);
    assign pop        = rec_valid && rec_ready;
    assign fifo_level = level;
    assign rec_data   = rec_valid ? mem[rd_ptr] : '0;

    // A dump landing on the channel being latched re-arms it and is not counted as a miss.
    logic [NUM_CH-1:0] pending_d;
    logic [5:0]        loss_cnt;
    logic [8:0]        drop_sum;
    logic [7:0]        drop_d;
    logic              ovf_d;

    always_comb begin
        pending_d = pending;
        loss_cnt  = 6'(push_drop);
        for (int c = 0; c < NUM_CH; c++) begin
            if ((state == StLatch) && (CH_W'(c) == cur_ch)) begin
                pending_d[c] = 1'b0;
            end else if (ch_dump[c] && pending[c]) begin
                loss_cnt = loss_cnt + 6'd1;
            end
            if (ch_dump[c]) pending_d[c] = 1'b1;
        end
        drop_sum = 9'(clr_ovf ? 8'd0 : drop_cnt) + 9'(loss_cnt);
        drop_d   = (drop_sum > 9'd255) ? 8'hff : drop_sum[7:0];
        ovf_d    = (ovf & ~clr_ovf) | (loss_cnt != 6'd0);
    end

    logic [REC_W-1:0] rec_new;
`ifdef CORR_DUMP_IQ_EN
    assign rec_new = {cur_ch, snap_seq, pow_e, pow_p, pow_l, snap[2], snap[3]};
`else
    assign rec_new = {cur_ch, snap_seq, pow_e, pow_p, pow_l};
`endif

    always_ff @(posedge clk) begin
        if (hw_rst) begin
            state    <= StIdle;
            pending  <= '0;
            for (int c = 0; c < NUM_CH; c++) seq[c] <= '0;
            ptr      <= '0;
            cur_ch   <= '0;
            for (int k = 0; k < 6; k++) snap[k] <= '0;
            snap_seq <= '0;
            mul_idx  <= '0;
            pow_e    <= '0;
            pow_p    <= '0;
            pow_l    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
            irq      <= 1'b0;
        end else begin
            pending  <= pending_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_dump[c]) seq[c] <= seq[c] + 8'd1;
            end
            ovf      <= ovf_d;
            drop_cnt <= drop_d;
            irq      <= (level != '0);

            unique case (state)
                StIdle: begin
                    if (sel_found) begin
                        cur_ch <= sel_ch;
                        state  <= StLatch;
                    end
                end
                StLatch: begin
                    for (int k = 0; k < 6; k++) snap[k] <= lat_val[k];
                    snap_seq <= lat_seq;
                    pow_e    <= '0;
                    pow_p    <= '0;
                    pow_l    <= '0;
                    mul_idx  <= '0;
                    ptr      <= (cur_ch == CH_W'(NUM_CH - 1)) ? '0 : cur_ch + 1'b1;
                    state    <= StMul;
                end
                StMul: begin
                    unique case (mul_idx[2:1])
                        2'd0:    pow_e <= pow_e + mul_sq;
                        2'd1:    pow_p <= pow_p + mul_sq;
                        default: pow_l <= pow_l + mul_sq;
                    endcase
                    mul_idx <= mul_idx + 3'd1;
                    if (mul_idx == 3'd5) state <= StPush;
                end
                StPush:  state <= StIdle;
                default: state <= StIdle;
            endcase

            if (push) begin
                mem[wr_ptr] <= rec_new;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + LVL_W'(push) - LVL_W'(pop);
        end
    end

endmodule

// File: tb/tb_corr_dump_engine.sv
// Bench for corr_dump_engine: directed scenarios plus random dumps against a transaction model.
module tb_corr_dump_engine;

    localparam int NUM_CH = 4;
    localparam int ACC_W  = 16;
    localparam int DEPTH  = 8;
    localparam int CH_W   = 2;
    localparam int PW     = 32;
    localparam int LVL_W  = 4;
`ifdef CORR_DUMP_IQ_EN
    localparam int IQW    = 32;
`else
    localparam int IQW    = 0;
`endif
    localparam int REC_W  = CH_W + 8 + 3 * PW + IQW;

    logic                      clk;
    logic                      hw_rst;
    logic [NUM_CH-1:0]         ch_dump;
    logic [NUM_CH*6*ACC_W-1:0] acc_flat;
    logic                      rec_valid;
    logic                      rec_ready;
    logic [REC_W-1:0]          rec_data;
    logic [LVL_W-1:0]          fifo_level;
    logic                      ovf;
    logic [7:0]                drop_cnt;
    logic                      clr_ovf;
    logic                      irq;

    corr_dump_engine #(
        .NUM_CH    (NUM_CH),
        .ACC_W     (ACC_W),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk       (clk),
        .hw_rst    (hw_rst),
        .ch_dump   (ch_dump),
        .acc_flat  (acc_flat),
        .rec_valid (rec_valid),
        .rec_ready (rec_ready),
        .rec_data  (rec_data),
        .fifo_level(fifo_level),
        .ovf       (ovf),
        .drop_cnt  (drop_cnt),
        .clr_ovf   (clr_ovf),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int errors = 0;
    int checks = 0;

    // Reference model state
    int               accv [NUM_CH][6];
    bit [NUM_CH-1:0]  m_pend;
    byte unsigned     m_seq [NUM_CH];
    int               m_ptr, m_cur, m_t;
    logic [REC_W-1:0] m_rec;
    logic [REC_W-1:0] m_q [$];
    int               m_drop;
    bit               m_ovf, m_irq;

    task automatic check(string tag, logic [159:0] obs, logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pack_acc();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 6; k++)
                acc_flat[(c * 6 + k) * ACC_W +: ACC_W] = 16'(accv[c][k]);
    endtask

    function automatic logic [REC_W-1:0] make_rec(int c, int s);
        longint pe, pp, pl;
        pe = longint'(accv[c][0]) * accv[c][0] + longint'(accv[c][1]) * accv[c][1];
        pp = longint'(accv[c][2]) * accv[c][2] + longint'(accv[c][3]) * accv[c][3];
        pl = longint'(accv[c][4]) * accv[c][4] + longint'(accv[c][5]) * accv[c][5];
`ifdef CORR_DUMP_IQ_EN
        return {2'(c), 8'(s), 32'(pe), 32'(pp), 32'(pl), 16'(accv[c][2]), 16'(accv[c][3])};
`else
        return {2'(c), 8'(s), 32'(pe), 32'(pp), 32'(pl)};
`endif
    endfunction

    task automatic model_reset();
        m_pend = '0;
        for (int c = 0; c < NUM_CH; c++) m_seq[c] = 0;
        m_ptr = 0; m_cur = 0; m_t = -1;
        m_q.delete();
        m_drop = 0; m_ovf = 0; m_irq = 0;
    endtask

    // m_t: -1 waiting for work, 0 capturing, 1..6 squaring, 7 delivering.
    task automatic model_step();
        bit [NUM_CH-1:0] old_pend;
        int losses, lat_c, nd;
        bit n_irq, do_pop, do_push, found;
        if (hw_rst) begin
            model_reset();
            return;
        end
        old_pend = m_pend;
        losses = 0; lat_c = -1; do_push = 0; found = 0;
        n_irq  = (m_q.size() != 0);
        do_pop = (m_q.size() != 0) && rec_ready;
        if (m_t < 0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = (m_ptr + i) % NUM_CH;
                if (!found && old_pend[c]) begin
                    found = 1; m_cur = c; m_t = 0;
                end
            end
        end else if (m_t == 0) begin
            lat_c = m_cur;
            m_rec = make_rec(m_cur, int'(m_seq[m_cur]));
            m_pend[m_cur] = 0;
            m_ptr = (m_cur + 1) % NUM_CH;
            m_t = 1;
        end else if (m_t < 7) begin
            m_t++;
        end else begin
            if (m_q.size() < DEPTH) do_push = 1;
            else losses++;
            m_t = -1;
        end
        if (do_pop) void'(m_q.pop_front());
        if (do_push) m_q.push_back(m_rec);
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_dump[c]) begin
                if (old_pend[c] && c != lat_c) losses++;
                m_pend[c] = 1;
                m_seq[c]++;
            end
        end
        nd = (clr_ovf ? 0 : m_drop) + losses;
        m_drop = (nd > 255) ? 255 : nd;
        m_ovf  = (clr_ovf ? 1'b0 : m_ovf) || (losses > 0);
        m_irq  = n_irq;
    endtask

    task automatic compare_all();
        check("valid", 160'(rec_valid), 160'(m_q.size() != 0));
        check("level", 160'(fifo_level), 160'(m_q.size()));
        check("data", 160'(rec_data), 160'((m_q.size() != 0) ? m_q[0] : '0));
        check("ovf", 160'(ovf), 160'(m_ovf));
        check("drop", 160'(drop_cnt), 160'(m_drop));
        check("irq", 160'(irq), 160'(m_irq));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        ch_dump = '0;
        clr_ovf = 1'b0;
        compare_all();
    endtask

    task automatic do_reset();
        hw_rst = 1'b1;
        tick();
        hw_rst = 1'b0;
    endtask

    task automatic pop_head();
        rec_ready = 1'b1;
        tick();
        rec_ready = 1'b0;
    endtask

    initial begin
        hw_rst = 1'b1; ch_dump = '0; rec_ready = 1'b0; clr_ovf = 1'b0; acc_flat = '0;
        for (int c = 0; c < NUM_CH; c++) for (int k = 0; k < 6; k++) accv[c][k] = 0;
        model_reset();
        pack_acc();
        tick();
        tick();
        hw_rst = 1'b0;
        check("rst_valid", 160'(rec_valid), 160'(0));
        check("rst_level", 160'(fifo_level), 160'(0));
        check("rst_irq", 160'(irq), 160'(0));

        // Single dump on ch2, record expected at cycle 9
        accv[2] = '{3, 4, -1000, 0, 0, -5};
        pack_acc();
        ch_dump = 4'b0100;
        tick();
        repeat (8) tick();
        check("c1_not_yet", 160'(rec_valid), 160'(0));
        tick();
        check("c1_valid", 160'(rec_valid), 160'(1));
        check("c1_ch", 160'(rec_data[IQW+104 +: 2]), 160'(2));
        check("c1_seq", 160'(rec_data[IQW+96 +: 8]), 160'(1));
        check("c1_powE", 160'(rec_data[IQW+64 +: 32]), 160'(25));
        check("c1_powP", 160'(rec_data[IQW+32 +: 32]), 160'(1000000));
        check("c1_powL", 160'(rec_data[IQW +: 32]), 160'(25));
`ifdef CORR_DUMP_IQ_EN
        check("c1_ip", 160'(rec_data[31:16]), 160'(16'hfc18));
        check("c1_qp", 160'(rec_data[15:0]), 160'(0));
`endif
        tick();
        check("c1_irq", 160'(irq), 160'(1));
        pop_head();

        // Most negative inputs everywhere
        for (int k = 0; k < 6; k++) accv[0][k] = -32768;
        pack_acc();
        ch_dump = 4'b0001;
        tick();
        repeat (9) tick();
        check("neg_powE", 160'(rec_data[IQW+64 +: 32]), 160'(32'h8000_0000));
        check("neg_powP", 160'(rec_data[IQW+32 +: 32]), 160'(32'h8000_0000));
        check("neg_powL", 160'(rec_data[IQW +: 32]), 160'(32'h8000_0000));
        pop_head();

        // All four channels at once from pointer 0
        do_reset();
        for (int c = 0; c < NUM_CH; c++)
            for (int k = 0; k < 6; k++) accv[c][k] = int'($urandom_range(65535)) - 32768;
        pack_acc();
        ch_dump = 4'hF;
        tick();
        repeat (36) tick();
        check("all4_level", 160'(fifo_level), 160'(4));
        for (int c = 0; c < NUM_CH; c++) begin
            check("all4_order", 160'(rec_data[IQW+104 +: 2]), 160'(c));
            pop_head();
        end

        // Overflow with consumer stalled, then clear
        do_reset();
        for (int i = 0; i < 10; i++) begin
            accv[i % 4][0] = i + 1;
            pack_acc();
            ch_dump[i % 4] = 1'b1;
            tick();
            repeat (9) tick();
        end
        check("full_level", 160'(fifo_level), 160'(8));
        check("full_drop", 160'(drop_cnt), 160'(2));
        check("full_ovf", 160'(ovf), 160'(1));
        clr_ovf = 1'b1;
        tick();
        check("clr_drop", 160'(drop_cnt), 160'(0));
        check("clr_ovf", 160'(ovf), 160'(0));
        check("clr_level", 160'(fifo_level), 160'(8));
        rec_ready = 1'b1;
        repeat (8) tick();
        rec_ready = 1'b0;

        // ch1 double dump while ch0 is being serviced
        do_reset();
        ch_dump = 4'b0001;
        tick();
        tick();
        ch_dump = 4'b0010;
        tick();
        tick();
        ch_dump = 4'b0010;
        tick();
        check("miss_drop", 160'(drop_cnt), 160'(1));
        check("miss_ovf", 160'(ovf), 160'(1));
        repeat (20) tick();
        check("miss_level", 160'(fifo_level), 160'(2));
        check("miss_ch0", 160'(rec_data[IQW+104 +: 2]), 160'(0));
        pop_head();
        check("miss_ch1", 160'(rec_data[IQW+104 +: 2]), 160'(1));
        check("miss_seq", 160'(rec_data[IQW+96 +: 8]), 160'(2));
        pop_head();

        // Reset while squaring discards the record
        ch_dump = 4'b1000;
        tick();
        repeat (4) tick();
        hw_rst = 1'b1;
        tick();
        hw_rst = 1'b0;
        check("mrst_valid", 160'(rec_valid), 160'(0));
        check("mrst_data", 160'(rec_data), 160'(0));
        check("mrst_drop", 160'(drop_cnt), 160'(0));
        check("mrst_ovf", 160'(ovf), 160'(0));
        repeat (12) tick();
        check("mrst_none", 160'(rec_valid), 160'(0));

        // Random traffic against the model
        do_reset();
        repeat (1500) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(9) == 0) begin
                    for (int k = 0; k < 6; k++) accv[c][k] = int'($urandom_range(65535)) - 32768;
                    ch_dump[c] = 1'b1;
                end
            end
            pack_acc();
            rec_ready = ($urandom_range(3) == 0);
            clr_ovf   = ($urandom_range(49) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
